risc16_imem_ctrl: RTL
=====================

Name: risc16_imem_ctrl

Overview:
- Sequences the RiSC-16 instruction memory and owns its address, data and write-enable lines.
- LOAD mode: streams program words from an external source into the memory at consecutive addresses, using a valid/ready handshake gated by program-enable `pen`.
- RUN mode: drives the memory address from an internal PC, advanced or redirected by the core.
- Sits between the system top, the external program source and the single-port instruction memory.

Parameters:
- WORD_LENGTH, 16, instruction/data word width.
- ADDR_WIDTH, 16, memory address width; capacity is 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  reset, asynchronous, active-low.
- pen  input  1  program enable (level); synchronised internally with a 2-flop synchroniser.
- in_valid  input  1  program word available.
- in_data  input  WORD_LENGTH  program word.
- in_ready  output  1  controller accepts a word this cycle.
- step  input  1  core requests PC+1 (RUN only).
- jump  input  1  core requests PC load (RUN only); has priority over step.
- jump_addr  input  ADDR_WIDTH  jump target.
- mem_addr  output  ADDR_WIDTH  instruction memory address.
- mem_wdata  output  WORD_LENGTH  instruction memory write data.
- mem_wen  output  1  instruction memory write enable.
- pc  output  ADDR_WIDTH  current PC.
- prog_len  output  ADDR_WIDTH+1  number of words loaded by the last load.
- running  output  1  high in RUN.
- overflow  output  1  sticky: a word was offered while memory was full.
- fault  output  1  out-of-bounds fetch; only when the optional feature is compiled in, else tied 0.

Behaviour:
- States: IDLE, LOAD, FULL, RUN, HALT (HALT is reachable only with the optional feature).
- Reset (rst low, async): state=IDLE, pc=0, load_addr=0, prog_len=0, overflow=0, fault=0; all outputs 0.
- pen_s is the synchronised pen; the rise/fall edge is detected from pen_s and its registered copy. Latency from a pen pin change to the state change is 3 clk.
- Rise of pen_s in any state goes to LOAD: load_addr=0, overflow=0, fault=0.
- LOAD:
  - in_ready=1.
  - mem_wen = in_valid & in_ready (combinational); mem_addr=load_addr; mem_wdata=in_data.
  - On each handshake, load_addr increments.
  - On the handshake at load_addr = 2**ADDR_WIDTH-1, go to FULL. load_addr does not wrap.
- FULL:
  - in_ready=0, mem_wen=0.
  - Any in_valid sets overflow.
- Fall of pen_s in LOAD or FULL goes to RUN:
  - prog_len = number of words accepted, including a handshake in the same cycle as the fall, and the full count 2**ADDR_WIDTH in FULL.
  - pc=0.
  - A handshake in the fall cycle is still written.
- Fall of pen_s in any other state: no effect.
- IDLE: in_ready=0, mem_wen=0, mem_addr=0.
- RUN:
  - running=1, mem_wen=0, mem_addr=pc (memory read latency is owned by the memory).
  - Each cycle: jump gives pc=jump_addr; else step gives pc=pc+1, wrapping mod 2**ADDR_WIDTH; else pc holds.
- A pen_s rise during RUN aborts run and enters LOAD on the next edge; step and jump are ignored in that cycle.
- pc output equals mem_addr in RUN, and holds its last value in other states.

Optional Feature:
- Macro: RISC16_IMEM_BOUND_CHECK_EN.
- Defined: in RUN, if the next pc would be >= prog_len, pc is not updated, fault is set, and the state goes to HALT. HALT holds pc, running=0, mem_wen=0, and is exited only by a pen_s rise or reset.
- Undefined: no bounds check, no HALT state, fault tied 0.

Decomposition:
- Shared package/defines header holds the state encoding constants (IDLE=0, LOAD=1, FULL=2, RUN=3, HALT=4; 3-bit) and the RISC16_IMEM_BOUND_CHECK_EN guard.
- Sub-module risc16_sync_edge: 2-flop synchroniser plus rise/fall pulse detector for pen.

Test Plan:
- Reset mid-LOAD after 5 words: rst low asynchronously gives all outputs 0 immediately and state IDLE; after release, in_ready=0 until the next pen rise.
- Load words 0x1111, 0x2222, 0x3333 with in_valid continuous, then drop pen: mem_wen pulses at mem_addr 0,1,2 with matching wdata; prog_len=3, running=1, pc=0.
- Load with in_valid toggling every other cycle: only handshake cycles write; addresses stay contiguous.
- RUN:
  - step x4 gives pc=4.
  - jump with jump_addr=0x0010 and step together gives pc=0x0010.
  - pc=0xFFFF plus step gives 0x0000 (feature off).
- ADDR_WIDTH=4: offer 17 words. 16 are accepted, state FULL, in_ready=0, the 17th sets overflow; after pen fall, prog_len=16.
- With RISC16_IMEM_BOUND_CHECK_EN, prog_len=3, step x3: pc stops at 2, fault=1, running=0; a pen rise clears fault and enters LOAD.

Source files
------------

// File: rtl/risc16_imem_ctrl_pkg.sv
// Shared types for the RiSC-16 instruction-memory controller.
// The optional bound check is enabled by defining RISC16_IMEM_BOUND_CHECK_EN.
package risc16_imem_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FULL = 3'd2,
        ST_RUN  = 3'd3,
        ST_HALT = 3'd4
    } imem_state_e;

endpackage

// File: rtl/risc16_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, with rise/fall pulses
// derived from the synchronised level and its registered copy.
module risc16_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_rise_c = r_sync & ~r_dly;
    assign o_fall_c = ~r_sync & r_dly;

endmodule

// File: rtl/risc16_imem_ctrl.sv
// RiSC-16 instruction memory sequencer: program LOAD via valid/ready, RUN via PC.
// Define RISC16_IMEM_BOUND_CHECK_EN to halt on fetches beyond the loaded program.
module risc16_imem_ctrl
    import risc16_imem_ctrl_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned ADDR_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pen,
    input  logic                    in_valid,
    input  logic [WORD_LENGTH-1:0]  in_data,
    output logic                    in_ready,
    input  logic                    step,
    input  logic                    jump,
    input  logic [ADDR_WIDTH-1:0]   jump_addr,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WORD_LENGTH-1:0]  mem_wdata,
    output logic                    mem_wen,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic [ADDR_WIDTH:0]     prog_len,
    output logic                    running,
    output logic                    overflow,
    output logic                    fault
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << ADDR_WIDTH) - 1);

    imem_state_e             r_state;
    imem_state_e             w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   w_pc_nxt;
    logic [ADDR_WIDTH-1:0]   w_pc_cand;
    logic [CW-1:0]           r_load_cnt;
    logic [CW-1:0]           w_load_cnt_nxt;
    logic [CW-1:0]           r_prog_len;
    logic [CW-1:0]           w_prog_len_nxt;
    logic                    r_overflow;
    logic                    w_overflow_nxt;
    logic                    w_pen_rise;
    logic                    w_pen_fall;
    logic                    w_hs;
`ifdef RISC16_IMEM_BOUND_CHECK_EN
    logic                    r_fault;
    logic                    w_fault_nxt;
`endif

    risc16_sync_edge u_pen_sync (
        .clk      (clk),
        .rst      (rst),
        .i_d      (pen),
        .o_rise_c (w_pen_rise),
        .o_fall_c (w_pen_fall)
    );

    assign w_hs      = in_valid & (r_state == ST_LOAD);
    assign w_pc_cand = jump ? jump_addr : r_pc + ADDR_WIDTH'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_load_cnt <= '0;
            r_prog_len <= '0;
            r_overflow <= 1'b0;
`ifdef RISC16_IMEM_BOUND_CHECK_EN
            r_fault    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_load_cnt <= w_load_cnt_nxt;
            r_prog_len <= w_prog_len_nxt;
            r_overflow <= w_overflow_nxt;
`ifdef RISC16_IMEM_BOUND_CHECK_EN
            r_fault    <= w_fault_nxt;
`endif
        end
    end

    // Next-state logic; a pen rise overrides everything, including step/jump
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_load_cnt_nxt = r_load_cnt;
        w_prog_len_nxt = r_prog_len;
        w_overflow_nxt = r_overflow;
`ifdef RISC16_IMEM_BOUND_CHECK_EN
        w_fault_nxt    = r_fault;
`endif
        if (w_pen_rise) begin
            w_state_nxt    = ST_LOAD;
            w_load_cnt_nxt = '0;
            w_overflow_nxt = 1'b0;
`ifdef RISC16_IMEM_BOUND_CHECK_EN
            w_fault_nxt    = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_pen_fall) begin
                        w_state_nxt    = ST_RUN;
                        w_prog_len_nxt = r_load_cnt + CW'(w_hs);
                        w_pc_nxt       = '0;
                    end else if (w_hs) begin
                        w_load_cnt_nxt = r_load_cnt + CW'(1);
                        if (r_load_cnt == CNT_LAST) begin
                            w_state_nxt = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (in_valid) begin
                        w_overflow_nxt = 1'b1;
                    end
                    if (w_pen_fall) begin
                        w_state_nxt    = ST_RUN;
                        w_prog_len_nxt = r_load_cnt;
                        w_pc_nxt       = '0;
                    end
                end
                ST_RUN: begin
                    if (jump || step) begin
`ifdef RISC16_IMEM_BOUND_CHECK_EN
                        if ({1'b0, w_pc_cand} >= r_prog_len) begin
                            w_fault_nxt = 1'b1;
                            w_state_nxt = ST_HALT;
                        end else begin
                            w_pc_nxt = w_pc_cand;
                        end
`else
                        w_pc_nxt = w_pc_cand;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory port steering by state
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_LOAD: begin
                mem_addr  = r_load_cnt[ADDR_WIDTH-1:0];
                mem_wdata = in_data;
            end
            ST_RUN: begin
                mem_addr = r_pc;
            end
            default: begin
            end
        endcase
    end

    assign in_ready = (r_state == ST_LOAD);
    assign mem_wen  = w_hs;
    assign pc       = r_pc;
    assign prog_len = r_prog_len;
    assign running  = (r_state == ST_RUN);
    assign overflow = r_overflow;
`ifdef RISC16_IMEM_BOUND_CHECK_EN
    assign fault    = r_fault;
`else
    assign fault    = 1'b0;
`endif

endmodule
